// File: rtl/swervolf_sevenseg_pkg.sv
// Shared types and constants for the SweRVolf seven-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package swervolf_sevenseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t       SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
   localparam seg_t SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/swervolf_hex7seg.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module swervolf_hex7seg
   import swervolf_sevenseg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/swervolf_sevenseg.sv
// Time-multiplexed 8-digit common-anode display driver with a per-frame input
// snapshot (no tearing) and a blanking gap at the start of every digit slot.
module swervolf_sevenseg
   import swervolf_sevenseg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_value,
   input  logic [7:0]  i_en,
   input  logic [7:0]  i_dp,
   output logic [7:0]  o_an,
   output logic [6:0]  o_seg,
   output logic        o_dp,
   output logic        o_frame
);

   localparam int              CW       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [31:0]     BLANK_U  = BLANK_CYCLES;

   generate
      if (DIGIT_CYCLES < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
         $error("swervolf_sevenseg: need DIGIT_CYCLES >= 2 and 0 <= BLANK_CYCLES < DIGIT_CYCLES");
      end
   endgenerate

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          first_q;
   logic [31:0]   shadow_value_q;
   logic [7:0]    shadow_en_q;
   logic [7:0]    shadow_dp_q;
   logic          frame_q;
   logic [7:0]    an_q, an_d;
   seg_t          seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          cnt_wrap;
   logic          snap;
   logic          blank;
   seg_t          digit_seg;

   assign cnt_wrap = (cnt_q == CNT_LAST);
   // First cycle out of reset, then once per frame as the last slot ends.
   assign snap     = first_q | (cnt_wrap & (idx_q == 3'd7));
   assign cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
   assign idx_d    = cnt_wrap ? idx_q + 3'd1 : idx_q;

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (32'(cnt_q) < BLANK_U);
      end
   endgenerate

   swervolf_hex7seg u_hex7seg (
      .nibble_i (shadow_value_q[{idx_q, 2'b00} +: 4]),
      .seg_o    (digit_seg)
   );

   // NOTE: every output gets its "off" value first, so no path leaves it unassigned.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (!blank && shadow_en_q[idx_q]) begin
         an_d  = ~(8'b1 << idx_q);
         seg_d = digit_seg;
         dp_d  = ~shadow_dp_q[idx_q];
      end
   end

   // NOTE: state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         idx_q          <= 3'd0;
         first_q        <= 1'b1;
         shadow_value_q <= 32'h0;
         shadow_en_q    <= 8'h0;
         shadow_dp_q    <= 8'h0;
         frame_q        <= 1'b0;
         an_q           <= AN_OFF;
         seg_q          <= SEG_OFF;
         dp_q           <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         first_q <= 1'b0;
         frame_q <= snap;
         if (snap) begin
            shadow_value_q <= i_value;
            shadow_en_q    <= i_en;
            shadow_dp_q    <= i_dp;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign o_an    = an_q;
   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_swervolf_sevenseg.sv
// Directed bench: slot scan, decode sweep, masks, tear-free update, async reset,
// and a zero-blank instance with short slots.
module tb_swervolf_sevenseg;

   logic        clk;
   logic        rst;
   logic [31:0] i_value;
   logic [7:0]  i_en;
   logic [7:0]  i_dp;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp;
   logic        o_frame;

   logic [31:0] v0;
   logic [7:0]  en0;
   logic [7:0]  dp0;
   logic [7:0]  an0;
   logic [6:0]  seg0;
   logic        dpo0;
   logic        frame0;

   int n_tests = 0;
   int n_fail  = 0;

   swervolf_sevenseg #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_value (i_value),
      .i_en    (i_en),
      .i_dp    (i_dp),
      .o_an    (o_an),
      .o_seg   (o_seg),
      .o_dp    (o_dp),
      .o_frame (o_frame)
   );

   swervolf_sevenseg #(.DIGIT_CYCLES(2), .BLANK_CYCLES(0)) u_dut0 (
      .clk     (clk),
      .rst     (rst),
      .i_value (v0),
      .i_en    (en0),
      .i_dp    (dp0),
      .o_an    (an0),
      .o_seg   (seg0),
      .o_dp    (dpo0),
      .o_frame (frame0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One 64-cycle frame of the 8/2 instance; segs packs digit glyphs {d7..d0}.
   // Optionally loads new inputs just after the check at offset chg.
   task automatic check_frame(input string tag, input logic [55:0] segs,
                              input logic [7:0] en, input logic [7:0] dp,
                              input bit first, input int chg,
                              input logic [31:0] nv, input logic [7:0] nen,
                              input logic [7:0] ndp);
      int         k, c;
      bit         lit;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp, exp_fr;
      for (int off = 0; off < 64; off++) begin
         @(posedge clk); #1;
         k       = off / 8;
         c       = off % 8;
         lit     = (c >= 2) && en[k];
         exp_an  = lit ? ~(8'b1 << k) : 8'hFF;
         exp_seg = lit ? segs[k*7 +: 7] : 7'h7F;
         exp_dp  = lit ? ~dp[k] : 1'b1;
         exp_fr  = (off == 63) || (first && off == 0);
         check($sformatf("%s off%0d an", tag, off), 32'(o_an), 32'(exp_an));
         check($sformatf("%s off%0d seg", tag, off), 32'(o_seg), 32'(exp_seg));
         check($sformatf("%s off%0d dp", tag, off), 32'(o_dp), 32'(exp_dp));
         check($sformatf("%s off%0d frame", tag, off), 32'(o_frame), 32'(exp_fr));
         if (off == chg) begin
            i_value = nv;
            i_en    = nen;
            i_dp    = ndp;
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      i_value = 32'h76543210;
      i_en    = 8'hFF;
      i_dp    = 8'h00;
      v0      = 32'h0;
      en0     = 8'hFF;
      dp0     = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("reset an", 32'(o_an), 32'hFF);
      check("reset seg", 32'(o_seg), 32'h7F);
      check("reset dp", 32'(o_dp), 32'h1);
      check("reset frame", 32'(o_frame), 32'h0);

      @(negedge clk);
      rst = 1'b0;

      // Scan of 76543210, then load the full decode sweep for the next frame.
      check_frame("scan", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40},
                  8'hFF, 8'h00, 1'b1, 0, 32'hFEDCBA98, 8'hFF, 8'h00);
      check_frame("sweep", {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00},
                  8'hFF, 8'h00, 1'b0, 0, 32'h76543210, 8'h05, 8'h04);
      check_frame("masks", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40},
                  8'h05, 8'h04, 1'b0, 0, 32'h00000000, 8'hFF, 8'h00);
      // New value arrives mid digit 3 (offset 28) but must wait for the next frame.
      check_frame("tear_old", {8{7'h40}}, 8'hFF, 8'h00, 1'b0, 28, 32'h11111111, 8'hFF, 8'h00);
      check_frame("tear_new", {8{7'h79}}, 8'hFF, 8'h00, 1'b0, -1, 32'h11111111, 8'hFF, 8'h00);

      // Into digit 5 SHOW phase (offset 44), then assert reset between edges.
      repeat (45) @(posedge clk);
      #1;
      check("pre-reset an", 32'(o_an), 32'hDF);
      check("pre-reset seg", 32'(o_seg), 32'h79);
      #2;
      rst = 1'b1;
      #1;
      check("async an", 32'(o_an), 32'hFF);
      check("async seg", 32'(o_seg), 32'h7F);
      check("async dp", 32'(o_dp), 32'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_frame("restart", {8{7'h79}}, 8'hFF, 8'h00, 1'b1, -1, 32'h11111111, 8'hFF, 8'h00);

      // Zero-blank, two-cycle slots: each anode held two cycles, frame every 16.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 34; t++) begin
         @(posedge clk); #1;
         check($sformatf("b0 t%0d frame", t), 32'(frame0),
               32'((t == 0) || (t == 15) || (t == 31)));
         if (t >= 1) begin
            check($sformatf("b0 t%0d an", t), 32'(an0), 32'(8'(~(8'b1 << ((t / 2) % 8)))));
            check($sformatf("b0 t%0d seg", t), 32'(seg0), 32'h40);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/swervolf_sevenseg.md
Name: swervolf_sevenseg

Overview:
Time-multiplexed 8-digit seven-segment display driver for the Nexys A7 top level. It consumes a 32-bit GPIO output word from the SweRVolf core (8 hex nibbles, plus per-digit enable and decimal-point masks) in the core clock domain. It drives the board's common-anode digit enables and cathode segments. Tearing is avoided by snapshotting inputs once per frame, and ghosting by inserting a blanking gap between digits.

Parameters:
DIGIT_CYCLES, 50000, clock cycles per digit slot (1 ms at 50 MHz); legal range >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; legal range 0 to DIGIT_CYCLES-1.

Ports:
clk  in  1  core clock (clk_core domain)
rst  in  1  reset, asynchronous, active-high
i_value  in  32  hex digits; nibble k (bits 4k+3:4k) shown on digit k
i_en  in  8  per-digit enable, 1 = digit lit
i_dp  in  8  per-digit decimal point, 1 = dot lit
o_an  out  8  digit anodes, active-low, bit k = digit k
o_seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
o_dp  out  1  decimal-point cathode, active-low
o_frame  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, immediate):
  - o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame=0.
  - cnt=0, idx=0, shadow registers=0.
  - Reset asserted mid-slot blanks the display in the same instant.
- Counters:
  - cnt has width $clog2(DIGIT_CYCLES) and counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - idx (3 bits) increments modulo 8 each time cnt wraps; 7 wraps to 0.
- Slot phases, combinational from cnt:
  - BLANK when cnt < BLANK_CYCLES.
  - SHOW otherwise.
  - With BLANK_CYCLES=0 there is no BLANK phase.
- Snapshot:
  - On the first cycle after reset release, and on every cycle where cnt wraps and idx wraps 7->0, latch i_value, i_en and i_dp into the shadow registers.
  - o_frame is registered and pulses high for exactly the cycle after the latch.
  - Input changes at any other time have no visible effect until the next snapshot.
- Outputs are registered, with one cycle of latency from (cnt, idx, shadow):
  - BLANK phase: o_an=8'hFF, o_seg=7'h7F, o_dp=1.
  - SHOW phase with shadow_en[idx]=1: o_an=~(8'b1<<idx), o_seg=hex decode of shadow nibble idx, o_dp=~shadow_dp[idx].
  - SHOW phase with shadow_en[idx]=0: same as BLANK (all off).
  - At most one anode is ever low.
- Hex decode (active-low, order g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Frame period: 8*DIGIT_CYCLES cycles. Each lit digit is on for DIGIT_CYCLES-BLANK_CYCLES consecutive cycles.
- Illegal parameters (BLANK_CYCLES >= DIGIT_CYCLES) are flagged by an elaboration-time $error.

Decomposition:
- Shared package swervolf_sevenseg_pkg holds:
  - the 16-entry segment constant table;
  - SEG_OFF=7'h7F and AN_OFF=8'hFF;
  - typedef seg_t (logic [6:0]).
- One combinational sub-module, swervolf_hex7seg (4-bit nibble in, seg_t out), instantiated once on the shadow nibble selected by idx.
- Top-level hookup: i_value=gpio_out[63:32], i_en and i_dp from a further GPIO register field.

Test Plan:
1. Reset release with DIGIT_CYCLES=8, BLANK_CYCLES=2, i_value=32'h76543210, i_en=8'hFF, i_dp=0:
   - o_frame pulses once.
   - Digit 0 slot: o_an=FF for 2 cycles, then FE with o_seg=40 for 6 cycles.
   - Digit 1 slot: FD with o_seg=79.
   - Continues up to digit 7 (7F, o_seg=78), then wraps to digit 0.
2. Full decode sweep: i_value=32'hFEDCBA98 -> digits 0..7 show 00, 10, 08, 03, 46, 21, 06, 0E.
3. Enable and decimal-point masks: i_en=8'h05, i_dp=8'h04 ->
   - o_an goes low only for digits 0 and 2; digits 1 and 3-7 stay FF for their whole slot.
   - o_dp=0 only during digit 2's SHOW phase.
4. Tear-free update: change i_value from 0 to 32'h11111111 while digit 3 is shown ->
   - digits 4-7 still show 40;
   - the new value appears from the next digit-0 slot, coincident with o_frame.
5. Asynchronous reset mid-SHOW on digit 5 -> o_an=FF, o_seg=7F and o_dp=1 immediately (before the next edge); after release, scanning restarts at digit 0.
6. BLANK_CYCLES=0, DIGIT_CYCLES=2 -> anodes step FE, FE, FD, FD, ... with no all-off cycles; the o_frame period is 16 cycles.
